// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory for the single-cycle ARMv4 core.
// Holds a word-addressed data RAM (ALUResult[31]=0) and a peripheral page
// (ALUResult[31]=1) containing a TX byte FIFO and a timer with compare IRQ.
// Loads are combinational. Stores take effect at the rising clock edge.
// Optional feature macro: DMEM_TIMER_EN builds TIMER_CNT, TIMER_CMP and irq.
// Without DMEM_TIMER_EN those addresses read 0 and irq is tied low.
module dmem_mmio #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   localparam logic [2:0] REG_TXDATA = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_TCNT   = 3'd2;
   localparam logic [2:0] REG_TCMP   = 3'd3;

   // ---------------------------------------------------------------
   // Address decode. Byte offset bits and RAM upper bits are ignored.
   // ---------------------------------------------------------------
   logic          is_periph;
   logic [2:0]    reg_sel;
   logic [AW-1:0] ram_idx;
   logic          unused_addr;

   assign is_periph   = ALUResult[31];
   assign reg_sel     = ALUResult[4:2];
   assign ram_idx     = ALUResult[AW+1:2];
   assign unused_addr = ^{ALUResult[30:AW+2], ALUResult[1:0]};

   logic ram_we;
   logic push_req;
   logic status_we;

   assign ram_we    = MemWrite && !is_periph;
   assign push_req  = MemWrite && is_periph && (reg_sel == REG_TXDATA);
   assign status_we = MemWrite && is_periph && (reg_sel == REG_STATUS);

   // ---------------------------------------------------------------
   // Data RAM: never cleared by reset; a store during reset is dropped.
   // ---------------------------------------------------------------
   logic [31:0] mem [RAM_WORDS];

   // Full-word store at the clock edge.
   always_ff @(posedge clk) begin
      if (rst && ram_we) begin
         mem[ram_idx] <= WriteData;
      end
   end

   // ---------------------------------------------------------------
   // TX FIFO.
   // Handshake: tx_valid is high whenever the FIFO holds a byte and
   // tx_data is its head; a byte is transferred in every cycle where
   // tx_valid && tx_ready at the rising edge. While tx_valid && !tx_ready
   // the head and tx_data stay unchanged.
   // ---------------------------------------------------------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic          drop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
   assign pop      = tx_valid && tx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // FIFO storage write for accepted pushes.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         fifo_mem[wr_ptr] <= WriteData[7:0];
      end
   end

   // Sticky overflow flag: set by a dropped push, cleared by writing 1 to STATUS[2].
   always_ff @(posedge clk) begin
      if (!rst)                         ovf <= 1'b0;
      else if (drop)                    ovf <= 1'b1;
      else if (status_we && WriteData[2]) ovf <= 1'b0;
   end

   // ---------------------------------------------------------------
   // Timer.
   // ---------------------------------------------------------------
   logic [31:0] tcnt_rd;
   logic [31:0] tcmp_rd;

`ifdef DMEM_TIMER_EN
   logic [31:0] cnt;
   logic [31:0] cmp;
   logic        irq_q;
   logic        tcnt_we;
   logic        tcmp_we;

   assign tcnt_we = MemWrite && is_periph && (reg_sel == REG_TCNT);
   assign tcmp_we = MemWrite && is_periph && (reg_sel == REG_TCMP);

   // Free-running counter; a TIMER_CNT store zeroes it ahead of the increment.
   always_ff @(posedge clk) begin
      if (!rst)         cnt <= '0;
      else if (tcnt_we) cnt <= '0;
      else              cnt <= cnt + 32'd1;
   end

   // Compare register.
   always_ff @(posedge clk) begin
      if (!rst)         cmp <= '0;
      else if (tcmp_we) cmp <= WriteData;
   end

   // Sticky match flag; a match in the same cycle as a clear keeps it set.
   always_ff @(posedge clk) begin
      if (!rst)                             irq_q <= 1'b0;
      else if ((cnt == cmp) && (cmp != '0)) irq_q <= 1'b1;
      else if (status_we && WriteData[8])   irq_q <= 1'b0;
   end

   assign irq     = irq_q;
   assign tcnt_rd = cnt;
   assign tcmp_rd = cmp;
`else
   assign irq     = 1'b0;
   assign tcnt_rd = '0;
   assign tcmp_rd = '0;
`endif

   // ---------------------------------------------------------------
   // Load path.
   // STATUS count field is 4 bits wide; with a 16-deep FIFO a full count
   // reads as 0 there, and software should rely on the full bit instead.
   // ---------------------------------------------------------------
   logic [31:0] status_word;

   assign status_word = {23'b0, irq, 4'(count), 1'b0, ovf, empty, full};

   // Combinational read mux over RAM and peripheral registers.
   always_comb begin
      ReadData = '0;
      if (!is_periph) begin
         ReadData = mem[ram_idx];
      end else begin
         case (reg_sel)
            REG_STATUS: ReadData = status_word;
            REG_TCNT:   ReadData = tcnt_rd;
            REG_TCMP:   ReadData = tcmp_rd;
            default:    ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed and randomized checks for dmem_mmio against a
// queue/array reference model. Inputs change on the falling edge; outputs are
// sampled before the following rising edge.
module tb_dmem_mmio;

   localparam int RAM_WORDS  = 64;
   localparam int FIFO_DEPTH = 4;

   localparam logic [31:0] A_TXDATA = 32'h8000_0000;
   localparam logic [31:0] A_STATUS = 32'h8000_0004;
   localparam logic [31:0] A_TCNT   = 32'h8000_0008;
   localparam logic [31:0] A_TCMP   = 32'h8000_000C;

   logic        clk;
   logic        rst;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        irq;

   dmem_mmio #(
      .RAM_WORDS  (RAM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .irq       (irq)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model / scoreboard ----------------
   logic [7:0]  exp_q [$];
   logic [31:0] ram_m [int];
   logic        m_ovf;
   logic        m_irq;
   logic [31:0] m_cnt;
   logic [31:0] m_cmp;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf = 1'b0;
      m_irq = 1'b0;
      m_cnt = '0;
      m_cmp = '0;
   endtask

   function automatic int ram_index(input logic [31:0] a);
      return int'((a >> 2) % RAM_WORDS);
   endfunction

   function automatic logic [31:0] exp_periph(input logic [2:0] r);
      logic [31:0] v;
      v = '0;
      case (r)
         3'd1: v = {23'b0, m_irq, 4'(exp_q.size()), 1'b0, m_ovf,
                    exp_q.size() == 0, exp_q.size() == FIFO_DEPTH};
`ifdef DMEM_TIMER_EN
         3'd2: v = m_cnt;
         3'd3: v = m_cmp;
`endif
         default: v = '0;
      endcase
      return v;
   endfunction

   // Check state-driven outputs, advance the model by one edge, then wait for it.
   task automatic cycle();
      logic pop;
      logic was_full;
      logic hit;
      check("tx_valid", tx_valid, exp_q.size() != 0);
      check("tx_data", tx_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      check("irq", irq, m_irq);
      if (!rst) begin
         model_reset();
      end else begin
         hit      = (m_cnt == m_cmp) && (m_cmp != 0);
         m_cnt    = m_cnt + 1;
         was_full = (exp_q.size() == FIFO_DEPTH);
         pop      = (exp_q.size() != 0) && tx_ready;
         if (pop) void'(exp_q.pop_front());
         if (MemWrite) begin
            if (!ALUResult[31]) begin
               ram_m[ram_index(ALUResult)] = WriteData;
            end else begin
               case (ALUResult[4:2])
                  3'd0: begin
                     if (!was_full || pop) exp_q.push_back(WriteData[7:0]);
                     else m_ovf = 1'b1;
                  end
                  3'd1: begin
                     if (WriteData[2]) m_ovf = 1'b0;
                     if (WriteData[8]) m_irq = 1'b0;
                  end
                  3'd2: m_cnt = '0;
                  3'd3: m_cmp = WriteData;
                  default: ;
               endcase
            end
         end
`ifdef DMEM_TIMER_EN
         if (hit) m_irq = 1'b1;
`else
         m_irq = 1'b0;
         hit   = 1'b0;
`endif
      end
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      ALUResult = a;
      WriteData = d;
      cycle();
      MemWrite  = 1'b0;
   endtask

   task automatic load_expect(input string tag, input logic [31:0] a, input logic [31:0] e);
      MemWrite  = 1'b0;
      ALUResult = a;
      #1;
      check(tag, ReadData, e);
   endtask

   task automatic load_model(input string tag, input logic [31:0] a);
      logic [31:0] e;
      MemWrite  = 1'b0;
      ALUResult = a;
      #1;
      if (!a[31]) begin
         if (!ram_m.exists(ram_index(a))) return;
         e = ram_m[ram_index(a)];
      end else begin
         e = exp_periph(a[4:2]);
      end
      check(tag, ReadData, e);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  drain_a [4];
      logic [7:0]  drain_b [4];
      logic [31:0] a;
      logic [31:0] d;
      int          op;

      drain_a = '{8'h11, 8'h22, 8'h33, 8'h44};
      drain_b = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

      rst       = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = '0;
      WriteData = '0;
      tx_ready  = 1'b0;
      model_reset();

      // Reset: two edges with rst low.
      @(negedge clk);
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_irq", irq, 1'b0);
      load_expect("rst_status", A_STATUS, 32'h0000_0002);
      rst = 1'b1;

      // RAM store, load, alias, unused peripheral slot.
      store(32'h0000_0010, 32'hDEAD_BEEF);
      load_expect("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
      load_expect("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
      load_expect("periph_5", 32'h8000_0014, 32'h0000_0000);
      load_expect("txdata_rd", A_TXDATA, 32'h0000_0000);

      // FIFO fill and overflow.
      tx_ready = 1'b0;
      store(A_TXDATA, 32'h11);
      store(A_TXDATA, 32'h22);
      store(A_TXDATA, 32'h33);
      store(A_TXDATA, 32'h44);
      store(A_TXDATA, 32'h55);
      load_expect("status_ovf_full", A_STATUS, 32'h0000_0045);
      cycle();
      check("hold_tx_data", tx_data, 8'h11);

      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_a", tx_data, drain_a[i]);
         cycle();
      end
      check("drain_a_empty", tx_valid, 1'b0);

      store(A_STATUS, 32'h0000_0004);
      load_expect("ovf_cleared", A_STATUS, 32'h0000_0002);

      // Simultaneous push and pop on a full FIFO.
      tx_ready = 1'b0;
      store(A_TXDATA, 32'hA1);
      store(A_TXDATA, 32'hA2);
      store(A_TXDATA, 32'hA3);
      store(A_TXDATA, 32'hA4);
      load_expect("status_full", A_STATUS, 32'h0000_0041);
      tx_ready = 1'b1;
      store(A_TXDATA, 32'h66);
      load_expect("status_pushpop", A_STATUS, 32'h0000_0041);
      for (int i = 0; i < 4; i++) begin
         check("drain_b", tx_data, drain_b[i]);
         cycle();
      end
      check("drain_b_empty", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // Timer match and irq clear.
`ifdef DMEM_TIMER_EN
      store(A_TCNT, 32'h0000_0000);
      store(A_TCMP, 32'h0000_0005);
      load_expect("tcmp_rd", A_TCMP, 32'h0000_0005);
      for (int n = 1; n <= 8; n++) begin
         check("irq_rise", irq, (n >= 6) ? 1'b1 : 1'b0);
         load_expect("tcnt_rd", A_TCNT, 32'(n));
         cycle();
      end
      store(A_STATUS, 32'h0000_0100);
      check("irq_clear", irq, 1'b0);
      load_expect("status_irq_clr", A_STATUS, 32'h0000_0002);
`else
      store(A_TCNT, 32'h0000_0000);
      store(A_TCMP, 32'h0000_0005);
      load_expect("tcnt_off", A_TCNT, 32'h0000_0000);
      load_expect("tcmp_off", A_TCMP, 32'h0000_0000);
      for (int n = 1; n <= 8; n++) begin
         check("irq_off", irq, 1'b0);
         cycle();
      end
`endif

      // Randomized traffic against the model.
      for (int it = 0; it < 400; it++) begin
         tx_ready = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 5);
         case (op)
            0: begin
               a = $urandom() & 32'h7FFF_FFFF;
               store(a, $urandom());
            end
            1: begin
               a = $urandom() & 32'h7FFF_FFFF;
               load_model("rnd_ram", a);
               cycle();
            end
            2: begin
               d = $urandom();
               store(A_TXDATA | ($urandom() & 32'h7FFF_FFE3), d);
            end
            3: begin
               a = $urandom() | 32'h8000_0000;
               load_model("rnd_periph", a);
               cycle();
            end
            4: begin
               a = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFE3;
               a = a | (32'($urandom_range(1, 7)) << 2);
               d = $urandom();
               if (a[4:2] == 3'd3) d = d & 32'h0000_003F;
               store(a, d);
            end
            default: begin
               MemWrite = 1'b0;
               cycle();
            end
         endcase
      end

      // Reset mid-drain discards queued bytes; RAM survives reset.
      tx_ready = 1'b0;
      store(32'h0000_0020, 32'hCAFE_F00D);
      store(A_STATUS, 32'h0000_0104);
      while (exp_q.size() != 0 && checks < 100000) begin
         tx_ready = 1'b1;
         cycle();
      end
      tx_ready = 1'b0;
      store(A_TXDATA, 32'h01);
      store(A_TXDATA, 32'h02);
      store(A_TXDATA, 32'h03);
      tx_ready = 1'b1;
      cycle();
      check("mid_drain_valid", tx_valid, 1'b1);
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      check("post_rst_valid", tx_valid, 1'b0);
      check("post_rst_data", tx_data, 8'h00);
      check("post_rst_irq", irq, 1'b0);
      load_expect("post_rst_status", A_STATUS, 32'h0000_0002);
      load_expect("post_rst_tcmp", A_TCMP, 32'h0000_0000);
      load_expect("ram_kept", 32'h0000_0020, 32'hCAFE_F00D);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
